// File: rtl/mopshub_can_tra_scheduler.sv
// mopshub_can_tra_scheduler: buffers elink uplink frames in a FIFO and dispatches them to the CAN transmit side
// with bus-id routing, timeout/retry and hardware-generated transmit-complete interrupt.
module mopshub_can_tra_scheduler #(
   parameter int N_BUSES = 32,
   parameter int FRAME_W = 76,
   parameter int DEPTH = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_RETRY = 2,
   parameter int IRQ_PULSE = 3,
   localparam int BUS_W = N_BUSES > 1 ? $clog2(N_BUSES) : 1,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               irq_elink,
   input  logic [FRAME_W-1:0] data_tra_uplink,
   output logic               start_read_elink,
   output logic               end_read_elink,
   output logic [BUS_W-1:0]   can_tra_select,
   output logic [FRAME_W-1:0] can_tra_data,
   output logic               send_mes_can,
   input  logic               send_mes_can_done,
   output logic               irq_can_tra,
   output logic               timeout_err,
   output logic               busid_err,
   output logic [AW:0]        fifo_level,
   output logic               busy
);
   localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
   localparam int PW = IRQ_PULSE > 1 ? $clog2(IRQ_PULSE) : 1;
   localparam int LW = AW + 1;
   localparam int BW1 = BUS_W + 1;
   localparam int RW1 = RW + 1;

   typedef enum logic [1:0] {I_IDLE, I_RD, I_CAP, I_GAP} ist_t;
   typedef enum logic [2:0] {E_IDLE, E_LOAD, E_SEND, E_RETRY, E_IRQ} est_t;

   ist_t ist;
   est_t est;
   logic [FRAME_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0] timer;
   logic [RW-1:0] retry_cnt;
   logic [PW-1:0] irq_cnt;
   logic [FRAME_W-1:0] head;
   logic [BUS_W-1:0] head_id;
   logic head_bad, push, pop, full, tmo, can_retry;

   assign head = mem[rd_ptr];
   assign head_id = head[FRAME_W-1 -: BUS_W];
   // zero-extend so the range check never degenerates when N_BUSES is a power of two
   assign head_bad = {1'b0, head_id} >= BW1'(N_BUSES);
   assign full = fifo_level == LW'(DEPTH);
   assign push = ist == I_CAP;
   assign pop = est == E_LOAD;
   assign tmo = timer == TW'(TIMEOUT_CYC - 1);
   assign can_retry = {1'b0, retry_cnt} < RW1'(MAX_RETRY);

   assign start_read_elink = ist == I_RD;
   assign end_read_elink = ist == I_CAP;
   assign send_mes_can = est == E_SEND;
   assign irq_can_tra = est == E_IRQ;
   assign busy = est != E_IDLE || fifo_level != '0;

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= data_tra_uplink;

   always_ff @(posedge clk)
      if (rst) begin
         ist <= I_IDLE;
         wr_ptr <= '0;
         fifo_level <= '0;
      end else begin
         case (ist)
            I_IDLE: if (irq_elink && !full) ist <= I_RD;
            I_RD: ist <= I_CAP;
            I_CAP: ist <= I_GAP;
            default: ist <= I_IDLE;
         endcase
         if (push) wr_ptr <= wr_ptr + 1'b1;
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
      end

   always_ff @(posedge clk)
      if (rst) begin
         est <= E_IDLE;
         rd_ptr <= '0;
         timer <= '0;
         retry_cnt <= '0;
         irq_cnt <= '0;
         can_tra_data <= '0;
         can_tra_select <= '0;
         timeout_err <= 1'b0;
         busid_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         busid_err <= 1'b0;
         case (est)
            E_IDLE: if (fifo_level != '0) est <= E_LOAD;
            E_LOAD: begin
               rd_ptr <= rd_ptr + 1'b1;
               can_tra_data <= head;
               can_tra_select <= head_id;
               timer <= '0;
               retry_cnt <= '0;
               busid_err <= head_bad;
               est <= head_bad ? E_IDLE : E_SEND;
            end
            E_SEND: begin
               timer <= timer + 1'b1;
               // completion takes priority over a timeout landing in the same cycle
               if (send_mes_can_done) begin
                  irq_cnt <= '0;
                  est <= E_IRQ;
               end else if (tmo && can_retry) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  est <= E_RETRY;
               end else if (tmo) begin
                  timeout_err <= 1'b1;
                  est <= E_IDLE;
               end
            end
            E_RETRY: begin
               timer <= '0;
               est <= E_SEND;
            end
            E_IRQ: begin
               irq_cnt <= irq_cnt + 1'b1;
               if (irq_cnt == PW'(IRQ_PULSE - 1)) est <= E_IDLE;
            end
            default: est <= E_IDLE;
         endcase
      end
endmodule

// File: tb/tb_mopshub_can_tra_scheduler.sv
// tb_mopshub_can_tra_scheduler: frame source, CAN responder and order/level scoreboard around the scheduler.
module tb_mopshub_can_tra_scheduler;
   localparam int NB = 20, FW = 76, DP = 4, TO = 1024, MR = 2, IP = 3;

   logic clk = 1'b0, rst = 1'b1, irq_elink = 1'b0, send_mes_can_done = 1'b0;
   logic [FW-1:0] data_tra_uplink = '0;
   logic start_read_elink, end_read_elink, send_mes_can, irq_can_tra, timeout_err, busid_err, busy;
   logic [4:0] can_tra_select;
   logic [FW-1:0] can_tra_data;
   logic [2:0] fifo_level;

   mopshub_can_tra_scheduler #(.N_BUSES(NB), .FRAME_W(FW), .DEPTH(DP), .TIMEOUT_CYC(TO),
                               .MAX_RETRY(MR), .IRQ_PULSE(IP)) dut (
      .clk(clk), .rst(rst), .irq_elink(irq_elink), .data_tra_uplink(data_tra_uplink),
      .start_read_elink(start_read_elink), .end_read_elink(end_read_elink),
      .can_tra_select(can_tra_select), .can_tra_data(can_tra_data), .send_mes_can(send_mes_can),
      .send_mes_can_done(send_mes_can_done), .irq_can_tra(irq_can_tra), .timeout_err(timeout_err),
      .busid_err(busid_err), .fifo_level(fifo_level), .busy(busy));

   always #5 clk = ~clk;

   typedef struct {int id; int dd; int n; int e_irq; int e_to; int e_bid;} vec_t;
   vec_t tv [8];

   int n_cmp = 0, n_err = 0;
   int n_irq = 0, n_to = 0, n_bid = 0;
   int dd = 0, scnt = 0;
   bit src_auto = 0, done_idle = 0;
   logic [FW-1:0] src_q [$];
   logic [FW-1:0] mq [$];
   logic [FW-1:0] e;
   bit in_frame = 0, prev_send = 0, prev_irq = 0;
   int attempts = 0, run = 0, gap = 0, last_run = 0, irq_run = 0, caps = 0, loads = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkd(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] mk(input int id);
      logic [FW-1:0] f;
      f[31:0] = $urandom();
      f[63:32] = $urandom();
      f[70:64] = 7'($urandom());
      f[FW-1 -: 5] = 5'(id);
      return f;
   endfunction

   task automatic push_frame(input int id);
      logic [FW-1:0] f;
      f = mk(id);
      src_q.push_back(f);
      mq.push_back(f);
   endtask

   task automatic wait_idle(input int lim);
      int q = 0;
      int i = 0;
      while (q < 3 && i < lim) begin
         @(negedge clk);
         i++;
         q = (!busy && src_q.size() == 0 && !irq_elink) ? q + 1 : 0;
      end
      chk("idle_reached", int'(busy), 0);
   endtask

   task automatic check_zero(input string p);
      chk({p, "_start"}, int'(start_read_elink), 0);
      chk({p, "_end"}, int'(end_read_elink), 0);
      chk({p, "_select"}, int'(can_tra_select), 0);
      chkd({p, "_data"}, can_tra_data, '0);
      chk({p, "_send"}, int'(send_mes_can), 0);
      chk({p, "_irq"}, int'(irq_can_tra), 0);
      chk({p, "_timeout"}, int'(timeout_err), 0);
      chk({p, "_busid"}, int'(busid_err), 0);
      chk({p, "_level"}, int'(fifo_level), 0);
      chk({p, "_busy"}, int'(busy), 0);
   endtask

   // elink source: presents queued frames, drops irq_elink once its queue drains
   initial forever begin
      @(negedge clk);
      if (rst) begin
         src_q.delete();
         irq_elink = 1'b0;
      end else if (src_auto) begin
         if (end_read_elink && src_q.size() != 0) data_tra_uplink = src_q.pop_front();
         irq_elink = src_q.size() != 0;
      end
   end

   // CAN responder: done in the (dd+1)-th cycle of every send period; dd < 0 means never
   initial forever begin
      @(negedge clk);
      if (rst || !send_mes_can) begin
         scnt = 0;
         send_mes_can_done = done_idle;
      end else begin
         send_mes_can_done = scnt == dd;
         scnt++;
      end
   end

   // scoreboard: frame order, retry spacing, pulse widths and occupancy = captured - dispatched
   initial forever begin
      @(negedge clk);
      if (rst) begin
         mq.delete();
         in_frame = 0; prev_send = 0; prev_irq = 0;
         attempts = 0; run = 0; gap = 0; last_run = 0; irq_run = 0; caps = 0; loads = 0;
      end else begin
         if (busid_err) begin
            e = mq.size() != 0 ? mq.pop_front() : '0;
            chk("busid_on_bad_frame", int'(busid_err), int'(e[FW-1 -: 5] >= 5'(NB)));
            loads++;
            n_bid++;
         end
         if (send_mes_can && !prev_send) begin
            if (in_frame) begin
               attempts++;
               chk("retry_gap", gap, 1);
               chk("retry_prev_run", last_run, TO);
            end else begin
               e = mq.size() != 0 ? mq.pop_front() : '0;
               chkd("tx_data", can_tra_data, e);
               chk("tx_select", int'(can_tra_select), int'(e[FW-1 -: 5]));
               chk("tx_bus_valid", int'(can_tra_select < 5'(NB)), 1);
               in_frame = 1;
               attempts = 1;
               loads++;
            end
            run = 0;
         end
         if (send_mes_can) run++;
         if (!send_mes_can && prev_send) begin
            last_run = run;
            gap = 0;
         end
         if (!send_mes_can) gap++;
         if (irq_can_tra && !prev_irq) begin
            chk("irq_follows_send", int'(prev_send), 1);
            if (dd >= 0) chk("send_len_to_done", last_run, dd + 1);
            irq_run = 0;
         end
         if (irq_can_tra) irq_run++;
         if (!irq_can_tra && prev_irq) begin
            chk("irq_len", irq_run, IP);
            n_irq++;
            in_frame = 0;
         end
         if (timeout_err) begin
            chk("timeout_attempts", attempts, MR + 1);
            chk("timeout_last_run", last_run, TO);
            n_to++;
            in_frame = 0;
         end
         chk("fifo_level", int'(fifo_level), caps - loads);
         if (end_read_elink) caps++;
         prev_send = send_mes_can;
         prev_irq = irq_can_tra;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FW-1:0] f;
      int i0, t0, b0, ns, k;
      bit seen;
      tv[0] = '{5, 10, 1, 1, 0, 0};
      tv[1] = '{25, 3, 1, 0, 0, 1};
      tv[2] = '{19, TO - 1, 1, 1, 0, 0};
      tv[3] = '{0, 0, 2, 2, 0, 0};
      tv[4] = '{7, -1, 1, 0, 1, 0};
      tv[5] = '{NB, 0, 1, 0, 0, 1};
      tv[6] = '{31, 5, 2, 0, 0, 2};
      tv[7] = '{12, 2, 3, 3, 0, 0};

      repeat (3) @(negedge clk);
      check_zero("reset");
      #2 rst = 1'b0;

      // single frame, bus 5, exact ingress/egress timing
      f = mk(5);
      mq.push_back(f);
      dd = 10;
      @(negedge clk); irq_elink = 1'b1; data_tra_uplink = f;
      @(negedge clk); chk("n1_start", int'(start_read_elink), 1); chk("n1_end", int'(end_read_elink), 0);
      @(negedge clk); chk("n2_start", int'(start_read_elink), 0); chk("n2_end", int'(end_read_elink), 1);
      irq_elink = 1'b0;
      @(negedge clk); chk("n3_level", int'(fifo_level), 1); chk("n3_end", int'(end_read_elink), 0);
      @(negedge clk); chk("n4_send", int'(send_mes_can), 0);
      @(negedge clk); chk("n5_send", int'(send_mes_can), 1); chk("n5_select", int'(can_tra_select), 5);
      repeat (10) @(negedge clk);
      chk("d_send", int'(send_mes_can), 1); chk("d_irq", int'(irq_can_tra), 0);
      @(negedge clk); chk("d1_irq", int'(irq_can_tra), 1); chk("d1_send", int'(send_mes_can), 0);
      repeat (2) @(negedge clk);
      chk("d3_irq", int'(irq_can_tra), 1);
      @(negedge clk); chk("d4_irq", int'(irq_can_tra), 0); chk("d4_busy", int'(busy), 0);
      chk("d4_level", int'(fifo_level), 0);

      // done while idle must be ignored
      i0 = n_irq;
      seen = 0;
      done_idle = 1;
      repeat (10) begin
         @(negedge clk);
         seen |= irq_can_tra | send_mes_can;
      end
      done_idle = 0;
      @(negedge clk);
      chk("done_outside_send", int'(seen), 0);
      chk("done_outside_send_irqs", n_irq - i0, 0);

      src_auto = 1;
      for (int i = 0; i < 8; i++) begin
         i0 = n_irq; t0 = n_to; b0 = n_bid;
         dd = tv[i].dd;
         for (int j = 0; j < tv[i].n; j++) push_frame(tv[i].id);
         wait_idle(4000 * tv[i].n + 500);
         chk($sformatf("vec%0d_irq", i), n_irq - i0, tv[i].e_irq);
         chk($sformatf("vec%0d_timeout", i), n_to - t0, tv[i].e_to);
         chk($sformatf("vec%0d_busid", i), n_bid - b0, tv[i].e_bid);
      end

      // burst of 6 with the first frame never acknowledged
      i0 = n_irq; t0 = n_to;
      dd = -1;
      for (int j = 0; j < 6; j++) push_frame($urandom_range(0, NB - 1));
      repeat (60) @(negedge clk);
      chk("burst_level_full", int'(fifo_level), DP);
      ns = 0;
      repeat (100) begin
         @(negedge clk);
         ns += int'(start_read_elink);
      end
      chk("ingress_stalled_when_full", ns, 0);
      k = 0;
      while (n_to == t0 && k < 3300) begin
         @(negedge clk);
         k++;
      end
      chk("burst_timeout_seen", n_to - t0, 1);
      dd = 5;
      wait_idle(3000);
      chk("burst_irqs", n_irq - i0, 5);
      chk("burst_timeouts", n_to - t0, 1);

      // randomized frames checked against queue/count model
      for (int r = 0; r < 3; r++) begin
         int nf, ev, eb, id;
         nf = 4 + $urandom_range(0, 6);
         ev = 0; eb = 0;
         i0 = n_irq; b0 = n_bid;
         dd = $urandom_range(0, 40);
         for (int j = 0; j < nf; j++) begin
            id = $urandom_range(0, 31);
            if (id < NB) ev++; else eb++;
            push_frame(id);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 12)) @(negedge clk);
         end
         wait_idle(4000);
         chk($sformatf("rand%0d_irq", r), n_irq - i0, ev);
         chk($sformatf("rand%0d_busid", r), n_bid - b0, eb);
      end

      // reset during E_SEND with 3 frames queued
      dd = -1;
      for (int j = 0; j < 4; j++) push_frame($urandom_range(0, NB - 1));
      k = 0;
      while (!(send_mes_can && fifo_level == 3) && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("pre_reset_queued", int'(send_mes_can && fifo_level == 3), 1);
      #2 rst = 1'b1;
      @(negedge clk);
      check_zero("mid_reset");
      #2 rst = 1'b0;
      i0 = n_irq; b0 = n_bid;
      dd = 3;
      @(negedge clk);
      push_frame(22);
      push_frame(9);
      wait_idle(2000);
      chk("post_reset_irq", n_irq - i0, 1);
      chk("post_reset_busid", n_bid - b0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mopshub_can_tra_scheduler.md
# mopshub_can_tra_scheduler

Parametrised uplink-to-CAN transmit scheduler between the elink read interface and the CAN transmit side of mopshubCore. It reads frames through the elink handshake and buffers them in a FIFO. It dispatches each frame to the bus selected by its bus-id field, then waits for the CAN controller's completion or a timeout with bounded retries. It generates the `irq_can_tra` pulse in hardware, so the bench no longer has to synthesise it.

## Interface
Parameters:
- `N_BUSES`, 32: number of CAN buses; `BUS_W` = max(1, $clog2(N_BUSES)) is derived.
- `FRAME_W`, 76: uplink frame width; bus id is `frame[FRAME_W-1 -: BUS_W]`.
- `DEPTH`, 4: FIFO depth; must be a power of 2 and at least 2.
- `TIMEOUT_CYC`, 1024: SEND cycles allowed before a timeout; must be at least 1.
- `MAX_RETRY`, 2: number of resends after a timeout before the frame is dropped.
- `IRQ_PULSE`, 3: width of `irq_can_tra` in cycles; must be at least 1.

Ports:
- `clk` in 1: the single clock, posedge.
- `rst` in 1: synchronous, active-high reset.
- `irq_elink` in 1: level; an elink frame is pending.
- `data_tra_uplink` in FRAME_W: frame data, valid in the cycle `end_read_elink` is high.
- `start_read_elink` out 1: read-start pulse.
- `end_read_elink` out 1: capture pulse.
- `can_tra_select` out BUS_W: target bus of the in-flight frame.
- `can_tra_data` out FRAME_W: the in-flight frame.
- `send_mes_can` out 1: transmit request, held as a level.
- `send_mes_can_done` in 1: the CAN side reports the transmission complete.
- `irq_can_tra` out 1: transmit-complete interrupt.
- `timeout_err` out 1: 1-cycle pulse; frame dropped after retries were exhausted.
- `busid_err` out 1: 1-cycle pulse; frame dropped because its bus id is >= N_BUSES.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.
- `busy` out 1: egress FSM is not in E_IDLE, or the FIFO is non-empty.

## Operation
Ingress FSM, states I_IDLE → I_RD → I_CAP → I_GAP → I_IDLE:
- I_IDLE goes to I_RD when `irq_elink` is high and the FIFO is not full.
- When the FIFO is full, `irq_elink` is ignored and the FSM stays in I_IDLE.
- I_RD: `start_read_elink`=1.
- I_CAP: `end_read_elink`=1; `data_tra_uplink` is pushed to the FIFO at the end of this cycle.
- I_GAP: one idle cycle so the source can deassert `irq_elink`.

Egress FSM, states E_IDLE, E_LOAD, E_SEND, E_RETRY, E_IRQ:
- E_IDLE goes to E_LOAD when the FIFO is non-empty.
- E_LOAD pops the head frame and registers `can_tra_data` and `can_tra_select`.
- E_LOAD clears the timer and `retry_cnt`.
- In E_LOAD, if bus id >= N_BUSES: pulse `busid_err`, discard the frame, return to E_IDLE.
- Otherwise E_LOAD goes to E_SEND.
- E_SEND: `send_mes_can`=1; the timer increments every cycle.
  - If `send_mes_can_done` is high, go to E_IRQ.
  - Else if timer == TIMEOUT_CYC-1 and retry_cnt < MAX_RETRY, go to E_RETRY and increment `retry_cnt`.
  - Else if timer == TIMEOUT_CYC-1 and retries are exhausted, pulse `timeout_err`, drop the frame, go to E_IDLE.
- E_RETRY: `send_mes_can`=0 for one cycle, the timer is cleared, then return to E_SEND.
- E_IRQ: `irq_can_tra`=1 for IRQ_PULSE cycles, `send_mes_can`=0, then go to E_IDLE.
- `can_tra_select` and `can_tra_data` hold their value until the next E_LOAD.

Boundary rules:
- `send_mes_can_done` and timeout in the same cycle: done wins.
- `send_mes_can_done` outside E_SEND is ignored.
- FIFO push and pop in the same cycle: both happen and `fifo_level` is unchanged.
- Pointers wrap modulo DEPTH.
- Pop never occurs when empty; push never occurs when full (the FSM guarantees this).
- Reset mid-operation discards all FIFO contents and the in-flight frame; no IRQ or error pulse is produced.

## Timing
Reset state:
- After any clock edge with `rst`=1, all outputs are 0.
- Both FSMs are in their IDLE state and FIFO pointers and level are 0.

Ingress:
- If `irq_elink` is sampled high in I_IDLE at edge N, `start_read_elink` is high in cycle N+1.
- `end_read_elink` is high in cycle N+2.
- `fifo_level` increments at N+3.
- The earliest next read starts at N+4 (`start_read_elink` high in cycle N+5).

Egress:
- FIFO non-empty at edge M: E_LOAD in cycle M+1, `send_mes_can` high from M+2.
- Done sampled at edge D: `send_mes_can` is low and `irq_can_tra` high for cycles D+1 … D+IRQ_PULSE.
- Back in E_IDLE at D+IRQ_PULSE+1.

Timeout:
- One SEND attempt lasts exactly TIMEOUT_CYC cycles, then the 1-cycle E_RETRY gap follows.
- Worst-case frame hold time is (MAX_RETRY+1)·TIMEOUT_CYC + MAX_RETRY + 2 cycles.

All outputs are registered or Moore-decoded from state; there are no combinational paths from inputs to outputs.

## Test plan
- Single frame with bus id 5, source deasserts `irq_elink` on `end_read_elink`, done returned 10 cycles after `send_mes_can` rises → `start_read_elink` and `end_read_elink` 1-cycle pulses at N+1 and N+2; `can_tra_select`=5; `irq_can_tra` high exactly 3 cycles; `fifo_level` returns to 0.
- Burst of 6 frames, done never returned for the first frame, TIMEOUT_CYC=1024, MAX_RETRY=2 → FIFO fills to 4 with ingress stalled; `send_mes_can` shows 3 high periods of 1024 cycles separated by 1-cycle gaps; one `timeout_err` pulse; the remaining frames drain in order with no `irq_can_tra` for the dropped frame.
- N_BUSES=20, frame with bus id 25 → `busid_err` 1 cycle, `send_mes_can` never rises, the next frame is processed normally.
- `send_mes_can_done` asserted in the same cycle the timer reaches TIMEOUT_CYC-1 → `irq_can_tra` pulse, no E_RETRY, no `timeout_err`.
- FIFO at level 2, push and pop in the same cycle → `fifo_level` stays at 2; check wrap-around after 9 frames with a reference-queue comparison of `can_tra_data`.
- `rst` asserted during E_SEND with 3 frames queued → next cycle all outputs are 0 and `fifo_level`=0; after release, new frames transmit normally.
